// File: rtl/dr_mem_seq.sv
// Purpose : sequences DR load enable / source select and the memory req/ack handshake for one command at a time.
// Latency : bus load done 2 cycles after accept; memory op done 1 cycle after the mem_ack cycle.
// Backpr. : cmd_ready is high only in IDLE; a command offered while busy is held by the requester.
//
// Ports:
//   clk, rst_b            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op (00 bus ld, 01 rd, 10 wr, 11 rsvd), cmd_addr
//   done, err             single-cycle completion / error pulses
//   mem_req, mem_we,      memory request held until ack (or timeout abort), direction, latched address
//   mem_addr, mem_ack     mem_ack: read data valid in the same cycle
//   dr_en, dr_sel         DR load enable and input mux select (0 bus, 1 memory)
//
// Optional feature macro: DR_SEQ_TIMEOUT_EN -- when defined, ACCESS aborts with err after
// TIMEOUT cycles without mem_ack; when undefined, ACCESS waits for mem_ack indefinitely.
module dr_mem_seq #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic          dr_en,
  output logic          dr_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSLD,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] OP_BUS = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;

  // The counter is 5 bits wide, so at most 32 wait cycles can be counted.
  if (TIMEOUT < 1 || TIMEOUT > 32) begin : g_bad_timeout
    $error("dr_mem_seq: TIMEOUT must be in 1..32");
  end

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;

  // Output flops are loaded from the next-state decode, so they always
  // equal a Moore decode of state_q while staying glitch-free.
  logic cmd_ready_q, done_q, err_q, mem_req_q, mem_we_q, busld_q;
  logic rd_ack;

`ifdef DR_SEQ_TIMEOUT_EN
  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
  logic [4:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
`ifdef DR_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
`ifdef DR_SEQ_TIMEOUT_EN
          cnt_d  = '0;
`endif
          case (cmd_op)
            OP_BUS:       state_d = S_BUSLD;
            OP_RD, OP_WR: state_d = S_ACCESS;
            default:      state_d = S_ERR;
          endcase
        end
      end
      S_BUSLD: state_d = S_DONE;
      S_ACCESS: begin
        // An ack in the expiry cycle still completes the access.
        if (mem_ack) begin
          state_d = S_DONE;
        end
`ifdef DR_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      op_q        <= OP_BUS;
      addr_q      <= '0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busld_q     <= 1'b0;
`ifdef DR_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cmd_ready_q <= (state_d == S_IDLE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
      mem_req_q   <= (state_d == S_ACCESS);
      mem_we_q    <= (state_d == S_ACCESS) && (op_d == OP_WR);
      busld_q     <= (state_d == S_BUSLD);
`ifdef DR_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Read data is only valid during the ack cycle, so the DR load on the
  // read path must be combinational on mem_ack.
  assign rd_ack = (state_q == S_ACCESS) && (op_q == OP_RD) && mem_ack;

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign dr_en     = busld_q | rd_ack;
  assign dr_sel    = rd_ack;

endmodule

// File: doc/dr_mem_seq.md
Name: dr_mem_seq

Overview:
Sequencer that owns the load enable of the 16-bit data register (DR) and the memory-port handshake.
- Accepts one command at a time from the control unit: bus load, memory read or memory write.
- Drives DR load enable and DR source select, and runs a request/acknowledge transaction on the memory port.
- Reports completion or error with single-cycle pulses.
- Sits between the control unit, DR and the memory interface.

Parameters:
AW, 16, memory address width in bits
TIMEOUT, 15, cycles in ACCESS without mem_ack before abort; must be >=1 and fit in a 5-bit counter

Ports:
clk  input  1  system clock, rising edge
rst_b  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 bus load, 01 mem read, 10 mem write, 11 reserved
cmd_addr  input  AW  memory address for ops 01/10
done  output  1  one-cycle pulse: command completed
err  output  1  one-cycle pulse: reserved op or timeout
mem_req  output  1  memory request, held until ack or abort
mem_we  output  1  1 = write (memory samples DR output), 0 = read
mem_addr  output  AW  latched command address
mem_ack  input  1  memory acknowledges; read data valid in the same cycle
dr_en  output  1  DR load enable
dr_sel  output  1  DR input mux select: 0 = internal bus, 1 = memory read data

Behaviour:
- Reset (async, rst_b=0): state IDLE.
  - cmd_ready=1. done=err=mem_req=mem_we=dr_en=dr_sel=0.
  - op register = 00. mem_addr=0. Timeout counter=0.
- States: IDLE, BUSLD, ACCESS, DONE, ERR. The state register is the only sequential element besides op, address and counter.
- IDLE:
  - cmd_ready=1.
  - Handshake when cmd_valid and cmd_ready are both 1 at a rising edge: latch cmd_op and cmd_addr.
  - Next state on handshake: op 00 -> BUSLD; op 01/10 -> ACCESS; op 11 -> ERR.
  - cmd_valid with cmd_ready=0 is ignored; the requester holds it.
- BUSLD: dr_en=1, dr_sel=0 for exactly one cycle -> DONE.
- ACCESS:
  - mem_req=1. mem_addr = latched address. mem_we=1 iff op=10.
  - Counter clears on ACCESS entry and increments each cycle mem_ack=0.
  - mem_ack=1 on a read: dr_en=1 and dr_sel=1 in that same cycle (Mealy), so DR captures memory data at that edge -> DONE.
  - mem_ack=1 on a write: dr_en stays 0 -> DONE.
  - Counter reaches TIMEOUT-1 with mem_ack=0 (timeout enabled): -> ERR. mem_req drops next cycle; DR is not loaded.
  - mem_ack arriving in the same cycle as expiry: the ack wins (complete, not error).
- DONE: done=1 for one cycle -> IDLE.
- ERR: err=1 for one cycle -> IDLE.
- Output behaviour:
  - All outputs except the read-path dr_en/dr_sel are Moore-decoded from state.
  - dr_sel=0 whenever dr_en=0.
  - mem_ack outside ACCESS is ignored.
- Latency, accept edge to done pulse:
  - Bus load: 2 cycles.
  - Memory access: ack cycle + 1.
  - Next command is accepted no earlier than the cycle after done/err.
- Reset mid-operation: immediate return to IDLE.
  - mem_req and dr_en deassert asynchronously.
  - No done/err pulse; the latched command is discarded.

Optional Feature:
DR_SEQ_TIMEOUT_EN
- Defined: ACCESS aborts after TIMEOUT cycles without mem_ack, with an err pulse as above.
- Undefined: counter logic is absent. ACCESS waits indefinitely for mem_ack, and err fires only for op 11.

Test Plan:
- Reset, then cmd_op=00 offered with cmd_valid -> accepted at edge 0; dr_en=1, dr_sel=0 in cycle 1; done=1 in cycle 2; cmd_ready=1 in cycle 3.
- cmd_op=01, cmd_addr=0x1234, mem_ack after 3 wait cycles -> mem_req=1, mem_we=0, mem_addr=0x1234 for 4 cycles; dr_en=dr_sel=1 only in the ack cycle; done next cycle.
- cmd_op=10, cmd_addr=0x00FF, immediate ack -> mem_we=1 for one cycle, dr_en never 1, done next cycle.
- cmd_op=11 -> err=1 one cycle after accept; no mem_req, no dr_en; back in IDLE.
- With DR_SEQ_TIMEOUT_EN and TIMEOUT=15: read with mem_ack never asserted -> mem_req high exactly 15 cycles, err=1, DR unchanged. Repeat with mem_ack in the 15th cycle -> done, no err. Without the macro: mem_req stays high at 100 cycles.
- rst_b pulsed low mid-ACCESS -> mem_req falls immediately, cmd_ready=1, no done/err; a following bus load completes normally.
